vga_glyph_serializer: RTL and testbench
=======================================

// Module: vga_glyph_serializer
// PURPOSE
//  Consumer stage of the 8x14 font RAM: takes one character cell (code, attribute, scanline row)
//  per handshake, issues the font byte address, captures the returned byte and serialises it
//  MSB-first into 8 pixel colour indices for the VGA pixel pipeline. Fetch of the next glyph
//  overlaps shifting of the current one, so the pixel stream is gapless at one pixel per cycle.
// PARAMETERS
//  FONT_HEIGHT   14      scanlines per glyph; font address = code*FONT_HEIGHT + row + FONT_BASE
//  FONT_BASE     13'h0   byte offset of glyph 0 in font RAM
//  CURSOR_START  12      first cursor scanline (only with VGA_GLYPH_CURSOR_EN)
//  CURSOR_END    13      last cursor scanline, inclusive (only with VGA_GLYPH_CURSOR_EN)
// PORTS
//  sys_clk      in   1   single clock, shared with font RAM
//  sys_rst      in   1   asynchronous, active-high reset
//  char_valid   in   1   upstream cell request valid
//  char_ready   out  1   cell accepted when char_valid & char_ready at a rising edge
//  char_code    in   8   character code
//  char_attr    in   8   [3:0] foreground index, [7:4] background index
//  char_row     in   4   scanline within cell, 0..FONT_HEIGHT-1
//  char_cursor  in   1   cell carries cursor (ignored without VGA_GLYPH_CURSOR_EN)
//  font_a       out  13  font RAM byte address, registered
//  font_dr      in   8   font RAM read data, valid the cycle after the RAM samples font_a
//  pix_valid    out  1   pix_color valid
//  pix_ready    in   1   downstream consumes a pixel when pix_valid & pix_ready
//  pix_color    out  4   pixel colour index
//  pix_last     out  1   high on 8th pixel of a glyph
// BEHAVIOUR
//  - Reset: font_a=0, pix_valid=0, pix_last=0, pix_color=0, char_ready=0 while sys_rst high,
//    all pipeline state cleared; a glyph mid-shift or mid-fetch is dropped, never resumed.
//  - Address: 13-bit unsigned, code*FONT_HEIGHT computed as (code<<4)-(code<<1) for default;
//    sum truncated mod 8192. Registered into font_a on the accept edge E0.
//  - Fetch: RAM samples font_a at E1, font_dr captured into hold register at E2 with attr/flags.
//    fetch_busy set at E0, cleared at E2. Only one fetch in flight.
//  - char_ready = ~sys_rst & ~fetch_busy & ~hold_valid (combinational from registers).
//  - Shifter: 8-bit glyph, attr, 3-bit index. Loads from hold when shifter empty, or on the
//    edge consuming pix_last if hold_valid (back-to-back, no bubble); hold_valid clears on load.
//  - pix_color = glyph[7-idx] ? attr[3:0] : attr[7:4]; idx advances only on pix_valid&pix_ready;
//    pix_valid/pix_color held stable while pix_ready low.
//  - Latency: accept edge E0 -> first pixel valid after E3 (3 cycles). Steady state 1 px/cycle.
//  - char_row >= FONT_HEIGHT: fetch still issued, captured byte forced to 8'h00 (bg only).
//  - Last pixel consumed with hold empty: pix_valid drops next cycle; shifter empty.
//  - Simultaneous hold load into shifter and font_dr capture into hold on same edge is legal;
//    new byte lands in hold, old hold moves to shifter.
// CONFIGURATION
//  VGA_GLYPH_CURSOR_EN defined: when char_cursor=1 and CURSOR_START<=char_row<=CURSOR_END,
//    captured byte forced to 8'hFF (full foreground bar). Not defined: char_cursor ignored,
//    no comparator logic; byte always from font_dr (or 8'h00 for out-of-range row).
// TESTING
//  1 reset mid-glyph: assert sys_rst at pixel 4 -> pix_valid=0, font_a=0 immediately; no stale px.
//  2 single cell code=8'h41,row=3,attr=8'h1F,font_dr=8'h3C -> font_a=13'd913;
//    pixels bg1,bg1,fg F x4,bg1,bg1; pix_last on 8th; first pixel 3 cycles after accept.
//  3 stream 16 cells, pix_ready=1, char_valid=1 -> 128 contiguous pix_valid cycles, no gap.
//  4 pix_ready toggled 50% -> pixel order/colours unchanged, pix_color stable while stalled.
//  5 code=8'hFF,row=13 -> font_a=13'd3583; row=14 -> font_a=13'd3584, all pixels background.
//  6 VGA_GLYPH_CURSOR_EN, char_cursor=1,row=12 -> all 8 pixels fg; row=11 -> font byte used.

Source files
------------

// File: rtl/vga_glyph_serializer.sv
// vga_glyph_serializer
//   Takes one character cell per handshake, fetches its font byte from the
//   8x14 font RAM and serialises it MSB-first into 4-bit colour indices.
//   A single-entry hold register sits between the fetch and the shifter, so
//   the next glyph is fetched while the current one shifts out. With a
//   continuous supply of cells the pixel stream has no gaps.
//
//   Optional feature macro: VGA_GLYPH_CURSOR_EN
//     defined   : cursor cells on rows CURSOR_START..CURSOR_END show a solid
//                 foreground bar
//     undefined : char_cursor is ignored and no cursor comparator is built
//
//   Fetch FSM states:
//     state  | meaning
//     F_IDLE | no fetch in flight, a new cell may be accepted
//     F_ADDR | font_a is presented, RAM samples it on the next edge
//     F_DATA | font_dr is valid, captured into hold on the next edge
module vga_glyph_serializer #(
  parameter int          FONT_HEIGHT  = 14,
  parameter logic [12:0] FONT_BASE    = 13'h0,
  parameter int          CURSOR_START = 12,
  parameter int          CURSOR_END   = 13
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_code,
  input  logic [7:0]  char_attr,
  input  logic [3:0]  char_row,
  input  logic        char_cursor,
  output logic [12:0] font_a,
  input  logic [7:0]  font_dr,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [3:0]  pix_color,
  output logic        pix_last
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ADDR = 2'd1,
    F_DATA = 2'd2
  } fetch_t;

  fetch_t      fetch_state;
  logic [7:0]  f_attr;
  logic        f_blank;

  logic [7:0]  hold_byte;
  logic [7:0]  hold_attr;
  logic        hold_valid;

  logic [7:0]  sh_glyph;
  logic [7:0]  sh_attr;
  logic [2:0]  sh_idx;
  logic        sh_valid;

  logic        fetch_busy;
  logic        accept;
  logic        capture;
  logic        fire;
  logic        at_last;
  logic        load;
  logic        row_bad;
  logic [7:0]  cap_byte;

  logic [12:0] code_ext;
  logic [12:0] code_scaled;
  logic [12:0] next_addr;

  assign code_ext = {5'b0, char_code};

  // Glyph base offset: the default 14-line font uses 16x-2x instead of a multiplier.
  generate
    if (FONT_HEIGHT == 14) begin : g_scale_shift
      assign code_scaled = (code_ext << 4) - (code_ext << 1);
    end else begin : g_scale_mul
      assign code_scaled = code_ext * 13'(FONT_HEIGHT);
    end
  endgenerate

  // Address arithmetic wraps modulo 8192 by construction of the 13-bit sum.
  assign next_addr = code_scaled + {9'b0, char_row} + FONT_BASE;
  assign row_bad   = ({1'b0, char_row} >= 5'(FONT_HEIGHT));

  assign fetch_busy = (fetch_state != F_IDLE);
  assign char_ready = ~sys_rst & ~fetch_busy & ~hold_valid;
  assign accept     = char_valid & char_ready;
  assign capture    = (fetch_state == F_DATA);

  assign at_last = (sh_idx == 3'd7);
  assign fire    = sh_valid & pix_ready;
  // Refill from hold when the shifter is empty or its last pixel leaves this edge.
  assign load    = hold_valid & (~sh_valid | (fire & at_last));

`ifdef VGA_GLYPH_CURSOR_EN
  logic f_bar;
  logic cursor_hit;

  assign cursor_hit = char_cursor
                    & ({1'b0, char_row} >= 5'(CURSOR_START))
                    & ({1'b0, char_row} <= 5'(CURSOR_END));

  // Cursor flag travels with the fetch so it is applied to the matching byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      f_bar <= 1'b0;
    end else if (accept) begin
      f_bar <= cursor_hit;
    end
  end

  // Out-of-range rows win over the cursor bar.
  always_comb begin
    cap_byte = font_dr;
    if (f_bar)   cap_byte = 8'hFF;
    if (f_blank) cap_byte = 8'h00;
  end
`else
  logic unused_cursor;
  localparam int unused_cursor_span = CURSOR_END - CURSOR_START;

  assign unused_cursor = char_cursor;

  // Font byte straight from RAM unless the row lies outside the glyph.
  always_comb begin
    cap_byte = font_dr;
    if (f_blank) cap_byte = 8'h00;
  end
`endif

  // Fetch sequencer: register the address on accept, then wait out the RAM read.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fetch_state <= F_IDLE;
      font_a      <= 13'h0;
      f_attr      <= 8'h00;
      f_blank     <= 1'b0;
    end else begin
      case (fetch_state)
        F_IDLE: begin
          if (accept) begin
            font_a      <= next_addr;
            f_attr      <= char_attr;
            f_blank     <= row_bad;
            fetch_state <= F_ADDR;
          end
        end
        F_ADDR:  fetch_state <= F_DATA;
        F_DATA:  fetch_state <= F_IDLE;
        default: fetch_state <= F_IDLE;
      endcase
    end
  end

  // Hold register: capture wins over the clear, so a same-edge load and capture keeps the new byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_byte  <= 8'h00;
      hold_attr  <= 8'h00;
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_byte  <= cap_byte;
      hold_attr  <= f_attr;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // Pixel shifter: index advances only on a consumed pixel, empties after the 8th.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_glyph <= 8'h00;
      sh_attr  <= 8'h00;
      sh_idx   <= 3'd0;
      sh_valid <= 1'b0;
    end else if (load) begin
      sh_glyph <= hold_byte;
      sh_attr  <= hold_attr;
      sh_idx   <= 3'd0;
      sh_valid <= 1'b1;
    end else if (fire) begin
      if (at_last) begin
        sh_valid <= 1'b0;
      end else begin
        sh_idx <= sh_idx + 3'd1;
      end
    end
  end

  assign pix_valid = sh_valid;
  assign pix_color = sh_glyph[3'd7 - sh_idx] ? sh_attr[3:0] : sh_attr[7:4];
  assign pix_last  = sh_valid & at_last;

endmodule

// File: tb/tb_vga_glyph_serializer.sv
// Bench for vga_glyph_serializer: synchronous font RAM model, per-pixel
// scoreboard filled on every accepted cell, scenario tasks run in sequence.
module tb_vga_glyph_serializer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_code;
  logic [7:0]  char_attr;
  logic [3:0]  char_row;
  logic        char_cursor;
  logic [12:0] font_a;
  logic [7:0]  font_dr;
  logic        pix_valid;
  logic        pix_ready;
  logic [3:0]  pix_color;
  logic        pix_last;

  int checks   = 0;
  int failures = 0;
  int px_seen  = 0;

  typedef struct packed {
    logic [3:0] color;
    logic       last;
  } px_t;

  px_t         exp_q[$];
  logic [7:0]  mem [0:8191];

  logic        addr_pending = 1'b0;
  logic [12:0] addr_exp;
  px_t         mon_e;
  logic [7:0]  mon_b;
  logic [12:0] mon_a;
  int          mon_ai;

  vga_glyph_serializer dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .char_code   (char_code),
    .char_attr   (char_attr),
    .char_row    (char_row),
    .char_cursor (char_cursor),
    .font_a      (font_a),
    .font_dr     (font_dr),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_color   (pix_color),
    .pix_last    (pix_last)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous font RAM: data valid the cycle after the address is sampled.
  always @(posedge sys_clk) font_dr <= mem[font_a];

  // Scoreboard: push expected pixels on accept, pop on every consumed pixel.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      exp_q.delete();
      addr_pending = 1'b0;
    end else begin
      if (addr_pending) begin
        checks++;
        if (font_a !== addr_exp) begin
          failures++;
          $display("FAIL font_a: got %0d expected %0d", font_a, addr_exp);
        end
        addr_pending = 1'b0;
      end
      if (pix_valid && pix_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pixel_extra: got color=%h last=%b expected no pixel", pix_color, pix_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (pix_color !== mon_e.color || pix_last !== mon_e.last) begin
            failures++;
            $display("FAIL pixel: got color=%h last=%b expected color=%h last=%b",
                     pix_color, pix_last, mon_e.color, mon_e.last);
          end
        end
        px_seen++;
      end
      if (char_valid && char_ready) begin
        mon_ai = (int'(char_code) * 14 + int'(char_row)) % 8192;
        mon_a  = 13'(mon_ai);
        mon_b  = mem[mon_a];
        if (char_row >= 4'd14) mon_b = 8'h00;
`ifdef VGA_GLYPH_CURSOR_EN
        else if (char_cursor && char_row >= 4'd12 && char_row <= 4'd13) mon_b = 8'hFF;
`endif
        for (int i = 0; i < 8; i++) begin
          mon_e.color = mon_b[7-i] ? char_attr[3:0] : char_attr[7:4];
          mon_e.last  = (i == 7);
          exp_q.push_back(mon_e);
        end
        addr_pending = 1'b1;
        addr_exp     = mon_a;
      end
    end
  end

  // Present one cell (caller sits just after a rising edge) and hold it until accepted.
  task automatic send_cell(input logic [7:0] code, input logic [7:0] attr,
                           input logic [3:0] row, input logic cur);
    int n;
    char_code   = code;
    char_attr   = attr;
    char_row    = row;
    char_cursor = cur;
    char_valid  = 1'b1;
    n = 0;
    while (1) begin
      @(negedge sys_clk);
      if (char_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got char_ready=0 for 200 cycles expected 1");
        break;
      end
    end
    @(posedge sys_clk); #1;
    char_valid = 1'b0;
  endtask

  // Wait for the pipeline and scoreboard to empty.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge sys_clk); #1;
      if (exp_q.size() == 0 && !pix_valid) break;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_%s: got queued=%0d pix_valid=%b expected 0 and 0", tag, exp_q.size(), pix_valid);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset();
    sys_rst     = 1'b1;
    char_valid  = 1'b0;
    char_code   = 8'h00;
    char_attr   = 8'h00;
    char_row    = 4'd0;
    char_cursor = 1'b0;
    pix_ready   = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks += 5;
    if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
    if (font_a !== 13'd0)   begin failures++; $display("FAIL reset_font_a: got %0d expected 0", font_a); end
    if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_char_ready: got %b expected 0", char_ready); end
    if (pix_last !== 1'b0)  begin failures++; $display("FAIL reset_pix_last: got %b expected 0", pix_last); end
    if (pix_color !== 4'd0) begin failures++; $display("FAIL reset_pix_color: got %h expected 0", pix_color); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (char_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b expected 1", char_ready); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_single_cell();
    char_code   = 8'h41;
    char_attr   = 8'h1F;
    char_row    = 4'd3;
    char_cursor = 1'b0;
    char_valid  = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (char_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", char_ready); end
    @(posedge sys_clk); #1;
    char_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sys_clk);
      checks++;
      if (pix_valid !== (k == 4)) begin
        failures++;
        $display("FAIL latency_cycle%0d: got pix_valid=%b expected %b", k, pix_valid, (k == 4));
      end
    end
    drain("single");
  endtask

  task automatic test_reset_mid_glyph();
    int base;
    int n;
    int stale;
    base = px_seen;
    send_cell(8'h41, 8'h1F, 4'd3, 1'b0);
    send_cell(8'h42, 8'h70, 4'd5, 1'b0);
    n = 0;
    while (px_seen - base < 4 && n < 100) begin
      @(negedge sys_clk); #1;
      n++;
    end
    checks++;
    if (px_seen - base < 4) begin
      failures++;
      $display("FAIL midglyph_reach: got %0d pixels expected 4", px_seen - base);
    end
    sys_rst = 1'b1;
    #1;
    checks += 3;
    if (pix_valid !== 1'b0)  begin failures++; $display("FAIL midglyph_pix_valid: got %b expected 0", pix_valid); end
    if (font_a !== 13'd0)    begin failures++; $display("FAIL midglyph_font_a: got %0d expected 0", font_a); end
    if (char_ready !== 1'b0) begin failures++; $display("FAIL midglyph_char_ready: got %b expected 0", char_ready); end
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    stale = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (pix_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL midglyph_stale: got %0d valid cycles expected 0", stale); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_stream();
    pix_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send_cell(8'(i * 7 + 3), 8'(8'h1E + i * 17), 4'(i % 14), 1'b0);
        end
      end
      begin
        int n;
        int gaps;
        n = 0;
        while (!pix_valid && n < 100) begin
          @(negedge sys_clk);
          n++;
        end
        gaps = 0;
        for (int i = 0; i < 128; i++) begin
          if (i > 0) @(negedge sys_clk);
          if (pix_valid !== 1'b1) gaps++;
        end
        checks++;
        if (gaps != 0) begin failures++; $display("FAIL stream_gaps: got %0d gap cycles expected 0", gaps); end
        @(negedge sys_clk);
        checks++;
        if (pix_valid !== 1'b0) begin failures++; $display("FAIL stream_end: got pix_valid=%b expected 0", pix_valid); end
      end
    join
    drain("stream");
  endtask

  task automatic test_stall();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_cell(8'(i * 29 + 5), 8'(8'h4B + i * 35), 4'(i * 2), 1'b0);
        end
      end
      begin
        repeat (250) begin
          @(posedge sys_clk); #1;
          pix_ready = 1'($urandom_range(0, 1));
        end
        pix_ready = 1'b1;
      end
      begin
        logic       prev_stall;
        logic [3:0] prev_color;
        logic       prev_last;
        prev_stall = 1'b0;
        prev_color = 4'd0;
        prev_last  = 1'b0;
        repeat (250) begin
          @(negedge sys_clk);
          if (prev_stall) begin
            checks++;
            if (pix_valid !== 1'b1 || pix_color !== prev_color || pix_last !== prev_last) begin
              failures++;
              $display("FAIL stall_hold: got valid=%b color=%h last=%b expected valid=1 color=%h last=%b",
                       pix_valid, pix_color, pix_last, prev_color, prev_last);
            end
          end
          prev_stall = pix_valid & ~pix_ready;
          prev_color = pix_color;
          prev_last  = pix_last;
        end
      end
    join
    drain("stall");
  endtask

  task automatic test_row_bounds();
    send_cell(8'hFF, 8'h2C, 4'd13, 1'b0);
    send_cell(8'hFF, 8'h2C, 4'd14, 1'b0);
    send_cell(8'h10, 8'h9A, 4'd15, 1'b0);
    send_cell(8'h00, 8'h5E, 4'd0, 1'b0);
    drain("rows");
  endtask

  task automatic test_cursor();
    send_cell(8'h20, 8'h2E, 4'd12, 1'b1);
    send_cell(8'h20, 8'h2E, 4'd11, 1'b1);
    send_cell(8'h20, 8'h2E, 4'd12, 1'b0);
    send_cell(8'h20, 8'h2E, 4'd13, 1'b1);
    drain("cursor");
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[913]  = 8'h3C;
    mem[3583] = 8'hC3;
    mem[3584] = 8'hA5;
    mem[459]  = 8'h5A;
    mem[460]  = 8'h5A;
    mem[461]  = 8'h81;

    test_reset();
    test_single_cell();
    test_reset_mid_glyph();
    test_stream();
    test_stall();
    test_row_bounds();
    test_cursor();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
